// File: rtl/corelet_ctrl.sv
// corelet_ctrl: tile sequencer for the weight-stationary corelet.
// Loads weights, streams activations, then drains the OFIFO to psum SRAM.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_bw  = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic               l0_full,
  input  logic               ofifo_valid,
  output logic [7:0]         inst,
  output logic               xmem_cen,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               pmem_wen,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               busy,
  output logic               done
);

  localparam int FLUSH = row + col;
  localparam int LMAX  = (1 << len_bw) - 1;
  localparam int CMAX  = (FLUSH > LMAX) ? FLUSH : LMAX;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0]     C_ONE = 1;
  localparam logic [len_bw-1:0] L_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLD,
    S_WKER,
    S_WFLUSH,
    S_ALD,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [len_bw-1:0] len_q, len_d;
  logic [len_bw-1:0] rd_q, rd_d;
  logic [len_bw-1:0] wr_q, wr_d;

  logic [7:0]         inst_q, inst_d;
  logic               xmem_cen_q, xmem_cen_d;
  logic [addr_bw-1:0] xmem_addr_q, xmem_addr_d;
  logic               pmem_wen_q, pmem_wen_d;
  logic [addr_bw-1:0] pmem_addr_q, pmem_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic w_end, a_end, x_rd, o_rd, p_wr;

  assign w_end = (cnt_q == CW'(col));
  assign a_end = (cnt_q == CW'(len_q));

  // A read is only launched when L0 has room at this edge
  assign x_rd = (((state_q == S_WLD) && !w_end) ||
                 ((state_q == S_ALD) && !a_end)) && !l0_full;

  assign o_rd = (state_q == S_DRAIN) && ofifo_valid && (rd_q < len_q);
  assign p_wr = inst_q[6];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      inst_q      <= 8'h00;
      xmem_cen_q  <= 1'b1;
      xmem_addr_q <= '0;
      pmem_wen_q  <= 1'b1;
      pmem_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      inst_q      <= inst_d;
      xmem_cen_q  <= xmem_cen_d;
      xmem_addr_q <= xmem_addr_d;
      pmem_wen_q  <= pmem_wen_d;
      pmem_addr_q <= pmem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          rd_d    = '0;
          wr_d    = '0;
          state_d = (len == '0) ? S_DONE : S_WLD;
        end
      end
      S_WLD: begin
        if (w_end) begin
          state_d = S_WKER;
          cnt_d   = '0;
        end else if (x_rd) begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_WKER: begin
        if (cnt_q == CW'(col - 1)) begin
          state_d = S_WFLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_WFLUSH: begin
        if (cnt_q == CW'(FLUSH - 1)) begin
          state_d = S_ALD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_ALD: begin
        if (a_end) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else if (x_rd) begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_EXEC: begin
        if (cnt_q == CW'(len_q) - C_ONE) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_DRAIN: begin
        if (o_rd) rd_d = rd_q + L_ONE;
        if (p_wr) wr_d = wr_q + L_ONE;
        if (wr_q == len_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_d      = 8'h00;
    xmem_cen_d  = ~x_rd;
    xmem_addr_d = xmem_addr_q;
    pmem_wen_d  = ~p_wr;
    pmem_addr_d = pmem_addr_q;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    // L0 write trails the xmem read by one cycle in every state
    inst_d[2]   = ~xmem_cen_q;
    if (x_rd) begin
      if (state_q == S_ALD)
        xmem_addr_d = addr_bw'(col) + addr_bw'(cnt_q);
      else
        xmem_addr_d = addr_bw'(cnt_q);
    end
    if (p_wr) pmem_addr_d = addr_bw'(wr_q);
    unique case (1'b1)
      (state_q == S_WKER): begin
        inst_d[3] = 1'b1;
        inst_d[0] = 1'b1;
      end
      (state_q == S_EXEC): begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      (state_q == S_DRAIN): inst_d[6] = o_rd;
      default: ;
    endcase
  end

  assign inst      = inst_q;
  assign xmem_cen  = xmem_cen_q;
  assign xmem_addr = xmem_addr_q;
  assign pmem_wen  = pmem_wen_q;
  assign pmem_addr = pmem_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
Instruction sequencer that drives the corelet's 8-bit inst word and its data-side SRAMs for one weight-stationary tile.
- On start it streams col weight vectors from activation/weight SRAM (xmem) into L0 and loads them into the MAC array.
- It then streams len activation vectors through L0 and executes them.
- Finally it drains the OFIFO into psum SRAM (pmem).
It is the initiator side of the corelet inst/o_valid interface and sits beside the corelet in the core top.

Parameters:
row, 8, MAC array rows (L0 lanes)
col, 8, MAC array columns (weight vectors per tile)
len_bw, 8, width of activation count len
addr_bw, 11, xmem/pmem address width

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  one-cycle request to run a tile; sampled in IDLE only
len  input  len_bw  number of activation vectors; captured with start
l0_full  input  1  L0 full flag from corelet
ofifo_valid  input  1  corelet o_valid (OFIFO has a row ready)
inst  output  8  [7] sfp_sel, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] kernel load
xmem_cen  output  1  xmem chip enable, active-low (read)
xmem_addr  output  addr_bw  xmem read address
pmem_wen  output  1  pmem write enable, active-low
pmem_addr  output  addr_bw  pmem write address
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at end of tile

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clock edge, from any state):
  - state=IDLE, all counters 0, inst=8'h00.
  - xmem_cen=1, pmem_wen=1, addresses 0, busy=0, done=0.
  - Mid-operation reset abandons the tile; no further SRAM or inst activity.
- inst[7], inst[5], inst[4] are always 0. In IDLE and DONE, inst=0.
- xmem read latency is 1 cycle: a read issued in cycle t produces l0_wr=1 in cycle t+1. Reads stop while state advances, but the in-flight write still completes.
- Memory map:
  - Weights at xmem addr 0..col-1.
  - Activations at col..col+len-1.
  - Outputs to pmem addr 0..len-1.
- States:
  - IDLE:
    - start=1, len>0 -> WLD, len latched.
    - start=1, len=0 -> DONE.
    - start while busy is ignored.
  - WLD: issue col reads at addr 0..col-1, one per cycle while l0_full=0. While l0_full=1, no read is issued and the counter holds. After the last read there is one trailing cycle for the final l0_wr, then -> WKER. Minimum 9 cycles at col=8.
  - WKER: col cycles with inst[3]=1 and inst[1:0]=2'b01, then -> WFLUSH.
  - WFLUSH: row+col cycles with inst=0 for the weights to settle, then -> ALD.
  - ALD: len reads at addr col+i, with the same stall and trailing-cycle rule as WLD, then -> EXEC.
  - EXEC: len cycles with inst[3]=1 and inst[1:0]=2'b10, then -> DRAIN.
  - DRAIN:
    - inst[6]=1 in each cycle where ofifo_valid=1 and reads_done<len.
    - In the following cycle, pmem_wen=0 with pmem_addr=read index.
    - After the len-th write -> DONE.
    - No timeout.
  - DONE: done=1 for 1 cycle, busy=1, then -> IDLE.
- Counters wrap-free: the addressed range is bounded by col+len ≤ 2^addr_bw. Behaviour outside that range is undefined.
- Simultaneous l0_full rising on the last WLD/ALD read cycle: that read is not issued; it is retried once l0_full falls.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> inst=00, xmem_cen=1, pmem_wen=1, busy=0, done=0 throughout.
- Nominal tile (row=col=8), len=4, l0_full=0:
  - xmem_addr 0..7 with cen=0 on 8 consecutive cycles; l0_wr lags by 1.
  - Then 8 cycles inst=8'h09.
  - Then 16 cycles inst=00.
  - Then reads at 8..11; then 4 cycles inst=8'h0A.
- Drain: after nominal EXEC, pulse ofifo_valid on 4 non-adjacent cycles -> 4 ofifo_rd pulses, each followed by pmem_wen=0 at addr 0,1,2,3; done pulses exactly once; then IDLE.
- Stall: in WLD, force l0_full=1 for 3 cycles after addr 3 -> no cen=0 for those cycles; resumes at addr 4; total 8 weight reads and 8 l0_wr.
- Edge cases:
  - start with len=0 -> busy for 1 cycle, done pulse, no SRAM access.
  - start asserted during EXEC -> ignored.
- Mid-run reset: assert reset=0 in EXEC -> next cycle IDLE, inst=00; a subsequent start runs a full clean tile.
